// File: rtl/led_mode_ctrl_pkg.sv
// Shared types and constants for the multi-channel LED mode controller.
package led_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF        = 2'd0,
    LED_MODE_BLINK_SLOW = 2'd1,
    LED_MODE_BLINK_FAST = 2'd2,
    LED_MODE_ON         = 2'd3
  } led_mode_t;

  localparam int CLOCK_HZ               = 50_000_000;
  localparam int FAST_TICK_CYCLES_50MHZ = 5_000_000;  // 100 ms at 50 MHz
  localparam int SLOW_TICK_MULT_DEFAULT = 4;

  // One step around the mode ring; fwd=1 is "next", fwd=0 is "prev".
  function automatic led_mode_t mode_step(input led_mode_t m, input logic fwd);
    led_mode_t r;
    case (m)
      LED_MODE_OFF:        r = fwd ? LED_MODE_BLINK_SLOW : LED_MODE_ON;
      LED_MODE_BLINK_SLOW: r = fwd ? LED_MODE_BLINK_FAST : LED_MODE_OFF;
      LED_MODE_BLINK_FAST: r = fwd ? LED_MODE_ON         : LED_MODE_BLINK_SLOW;
      LED_MODE_ON:         r = fwd ? LED_MODE_OFF        : LED_MODE_BLINK_FAST;
      default:             r = LED_MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_channel.sv
// One LED channel: mode register plus registered LED output driven from the mode.
module led_channel
  import led_mode_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset_s2_n,
  input  logic next_en,
  input  logic prev_en,
  input  logic fast_tick,
  input  logic slow_tick,
  output logic led
);

  led_mode_t mode_q, mode_d;
  logic      led_q, led_d;

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    // LED update uses the mode as it stands this cycle, so a simultaneous press
    // only affects the LED one edge later.
    case (mode_q)
      LED_MODE_OFF:        led_d = 1'b0;
      LED_MODE_ON:         led_d = 1'b1;
      LED_MODE_BLINK_SLOW: if (slow_tick) led_d = ~led_q;
      LED_MODE_BLINK_FAST: if (fast_tick) led_d = ~led_q;
      default: begin
        led_d  = 1'b0;
        mode_d = LED_MODE_OFF;
      end
    endcase
    if (next_en)      mode_d = mode_step(mode_q, 1'b1);
    else if (prev_en) mode_d = mode_step(mode_q, 1'b0);
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      mode_q <= LED_MODE_OFF;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Multi-channel LED mode controller: shared tick generator, channel select, per-channel mode FSMs.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter  int LED_COUNT        = 4,
  parameter  int FAST_TICK_CYCLES = FAST_TICK_CYCLES_50MHZ,
  parameter  int SLOW_TICK_MULT   = SLOW_TICK_MULT_DEFAULT,
  localparam int SEL_W            = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                 clock,
  input  logic                 reset_s2_n,
  input  logic                 next_pressed,
  input  logic                 prev_pressed,
  input  logic                 select_pressed,
  output logic [LED_COUNT-1:0] led,
  output logic [SEL_W-1:0]     sel
);

  localparam int FC_W = $clog2(FAST_TICK_CYCLES);
  localparam int SC_W = $clog2(SLOW_TICK_MULT);

  logic [FC_W-1:0]      fast_cnt_q, fast_cnt_d;
  logic [SC_W-1:0]      slow_cnt_q, slow_cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 fast_tick, slow_tick;
  logic [LED_COUNT-1:0] next_en, prev_en, led_w;

  assign fast_tick = (fast_cnt_q == FC_W'(FAST_TICK_CYCLES - 1));
  assign slow_tick = fast_tick && (slow_cnt_q == SC_W'(SLOW_TICK_MULT - 1));

  always_comb begin
    fast_cnt_d = fast_tick ? '0 : fast_cnt_q + 1'b1;
    slow_cnt_d = slow_cnt_q;
    if (fast_tick) slow_cnt_d = slow_tick ? '0 : slow_cnt_q + 1'b1;
    sel_d = sel_q;
    if (select_pressed)
      sel_d = (sel_q == SEL_W'(LED_COUNT - 1)) ? '0 : sel_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      fast_cnt_q <= '0;
      slow_cnt_q <= '0;
      sel_q      <= '0;
    end else begin
      fast_cnt_q <= fast_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      sel_q      <= sel_d;
    end
  end

  // Select wins over next/prev; next and prev together cancel.
  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    assign next_en[i] = next_pressed & ~prev_pressed & ~select_pressed & (sel_q == SEL_W'(i));
    assign prev_en[i] = prev_pressed & ~next_pressed & ~select_pressed & (sel_q == SEL_W'(i));

    led_channel u_ch (
      .clock      (clock),
      .reset_s2_n (reset_s2_n),
      .next_en    (next_en[i]),
      .prev_en    (prev_en[i]),
      .fast_tick  (fast_tick),
      .slow_tick  (slow_tick),
      .led        (led_w[i])
    );
  end

  assign led = led_w;
  assign sel = sel_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with LED_COUNT=3, FAST_TICK_CYCLES=4, SLOW_TICK_MULT=2.
module tb_led_mode_ctrl;

  localparam int N  = 3;
  localparam int FT = 4;
  localparam int SM = 2;

  logic         clock = 1'b0;
  logic         reset_s2_n;
  logic         next_pressed, prev_pressed, select_pressed;
  logic [N-1:0] led;
  logic [1:0]   sel;

  led_mode_ctrl #(.LED_COUNT(N), .FAST_TICK_CYCLES(FT), .SLOW_TICK_MULT(SM)) dut (
    .clock          (clock),
    .reset_s2_n     (reset_s2_n),
    .next_pressed   (next_pressed),
    .prev_pressed   (prev_pressed),
    .select_pressed (select_pressed),
    .led            (led),
    .sel            (sel)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] led;
    logic [1:0]   sel;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: modes 0=OFF 1=SLOW 2=FAST 3=ON
  int         m_mode [N];
  logic [N-1:0] m_led;
  int         m_sel, m_fc, m_sc;

  task automatic chk(input string tag, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_mode[c] = 0;
    m_led = '0;
    m_sel = 0;
    m_fc  = 0;
    m_sc  = 0;
  endtask

  task automatic model_edge(input logic n, input logic p, input logic s);
    logic fast, slow;
    exp_t e;
    fast = (m_fc == FT - 1);
    slow = fast && (m_sc == SM - 1);
    for (int c = 0; c < N; c++) begin
      case (m_mode[c])
        0: m_led[c] = 1'b0;
        1: if (slow) m_led[c] = ~m_led[c];
        2: if (fast) m_led[c] = ~m_led[c];
        default: m_led[c] = 1'b1;
      endcase
      if (!s && (n != p) && (m_sel == c))
        m_mode[c] = n ? (m_mode[c] + 1) % 4 : (m_mode[c] + 3) % 4;
    end
    if (s) m_sel = (m_sel + 1) % N;
    if (fast) m_sc = (m_sc == SM - 1) ? 0 : m_sc + 1;
    m_fc = fast ? 0 : m_fc + 1;
    e.led = m_led;
    e.sel = m_sel[1:0];
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, push the expected post-edge outputs, compare just after the edge.
  task automatic cyc(input logic n, input logic p, input logic s, input string tag);
    exp_t e;
    next_pressed   = n;
    prev_pressed   = p;
    select_pressed = s;
    model_edge(n, p, s);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".led"}, int'(led), int'(e.led));
    chk({tag, ".sel"}, int'(sel), int'(e.sel));
    next_pressed   = 1'b0;
    prev_pressed   = 1'b0;
    select_pressed = 1'b0;
  endtask

  task automatic idle(input int k, input string tag);
    for (int j = 0; j < k; j++) cyc(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int guard;
    reset_s2_n     = 1'b0;
    next_pressed   = 1'b0;
    prev_pressed   = 1'b0;
    select_pressed = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst.led", int'(led), 0);
    chk("rst.sel", int'(sel), 0);
    reset_s2_n = 1'b1;

    // idle after reset: everything dark, sel 0
    idle(40, "idle");

    // channel 0 to slow blink
    cyc(1'b1, 1'b0, 1'b0, "ch0_next");
    idle(24, "slow");

    // select channel 2, walk it to ON
    cyc(1'b0, 1'b0, 1'b1, "sel1");
    cyc(1'b0, 1'b0, 1'b1, "sel2");
    chk("sel_is_2", int'(sel), 2);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, "ch2_next");
    cyc(1'b0, 1'b0, 1'b0, "ch2_lat");
    chk("ch2_on", int'(led[2]), 1);
    cyc(1'b0, 1'b0, 1'b1, "sel_wrap");
    chk("sel_wrap0", int'(sel), 0);

    // conflicting pulses
    cyc(1'b1, 1'b1, 1'b0, "np_both");
    idle(3, "np_after");
    cyc(1'b1, 1'b0, 1'b1, "sel_next");
    chk("sel_is_1", int'(sel), 1);
    idle(10, "sn_after");

    // channel 1 to fast blink, then reset while its LED is lit
    cyc(1'b1, 1'b0, 1'b0, "ch1_n1");
    cyc(1'b1, 1'b0, 1'b0, "ch1_n2");
    guard = 0;
    while (m_led[1] !== 1'b1 && guard < 12) begin
      cyc(1'b0, 1'b0, 1'b0, "fast_wait");
      guard++;
    end
    chk("fast_lit_before_rst", int'(led[1]), 1);
    reset_s2_n = 1'b0;
    #1;
    chk("rst_async.led", int'(led), 0);
    chk("rst_async.sel", int'(sel), 0);
    model_reset();
    @(posedge clock);
    #1;
    chk("rst_hold.led", int'(led), 0);
    reset_s2_n = 1'b1;

    // prev from OFF -> ON, prev again -> FAST; LED holds 1 until first fast tick at edge 4
    cyc(1'b0, 1'b1, 1'b0, "prev_on");
    cyc(1'b0, 1'b1, 1'b0, "prev_fast");
    chk("ch0_on_led", int'(led[0]), 1);
    cyc(1'b0, 1'b0, 1'b0, "hold3");
    chk("ch0_hold", int'(led[0]), 1);
    cyc(1'b0, 1'b0, 1'b0, "tick4");
    chk("ch0_first_toggle", int'(led[0]), 0);
    idle(16, "fast");

    // random mix of pulses
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 11);
      cyc(r == 0 || r == 3 || r == 4, r == 1 || r == 3, r == 2 || r == 4, "rand");
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
